// File: rtl/frame_buf_multi.sv
// frame_buf_multi: single-clock ring of NUM_BUFS frame buffers. Whole frames are
// written by one stream and handed, in FIFO order, to a second stream.
module frame_buf_multi #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned NUM_BUFS   = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wr_en_in,
    input  logic                            rd_en_in,
    input  logic [DATA_WIDTH-1:0]           data_in,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            data_valid,
    output logic                            wr_rdy,
    output logic                            frame_rdy,
    output logic [$clog2(NUM_BUFS+1)-1:0]   buf_count,
    output logic                            overflow
);

    localparam int unsigned FRAME_LEN = 1 << ADDR_WIDTH;
    localparam int unsigned BUF_W     = $clog2(NUM_BUFS);
    localparam int unsigned CNT_W     = $clog2(NUM_BUFS + 1);
    localparam int unsigned DEPTH     = NUM_BUFS * FRAME_LEN;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [BUF_W-1:0]      LAST_BUF  = BUF_W'(NUM_BUFS - 1);
    localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(NUM_BUFS);

    typedef enum logic {WIdle, WFill} w_state_t;
    typedef enum logic {RIdle, RRead} r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [BUF_W-1:0]      wr_buf;
    logic [BUF_W-1:0]      rd_buf;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;

    logic wr_fire;
    logic rd_fire;
    logic commit;
    logic rel;

    // Readiness depends on registered state only, never on the enables.
    assign wr_rdy    = (w_state == WFill) || (buf_count < FULL_CNT);
    assign frame_rdy = (buf_count != '0);

    assign wr_fire = !wr_en_in && wr_rdy;
    assign rd_fire = !rd_en_in && ((r_state == RRead) || frame_rdy);
    assign commit  = wr_fire && (wr_addr == LAST_ADDR);
    assign rel     = rd_fire && (rd_addr == LAST_ADDR);

    // Frame storage, indexed {buffer, word}; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wr_buf, wr_addr}] <= data_in;
        end
    end

    // Write FSM: fills wr_buf word by word, commits on the last word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state  <= WIdle;
            wr_buf   <= '0;
            wr_addr  <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= !wr_en_in && !wr_rdy;
            case (w_state)
                WIdle: begin
                    if (wr_fire) begin
                        wr_addr <= wr_addr + ADDR_WIDTH'(1);
                        w_state <= WFill;
                    end
                end
                WFill: begin
                    if (wr_fire) begin
                        // Address wraps to 0 after the last word.
                        wr_addr <= wr_addr + ADDR_WIDTH'(1);
                        if (commit) begin
                            wr_buf  <= (wr_buf == LAST_BUF) ? '0 : wr_buf + BUF_W'(1);
                            w_state <= WIdle;
                        end
                    end
                end
                default: w_state <= WIdle;
            endcase
        end
    end

    // Read FSM with registered read port; releases rd_buf on the last word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= RIdle;
            rd_buf     <= '0;
            rd_addr    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_fire;
            if (rd_fire) begin
                data_out <= mem[{rd_buf, rd_addr}];
            end
            case (r_state)
                RIdle: begin
                    if (rd_fire) begin
                        rd_addr <= rd_addr + ADDR_WIDTH'(1);
                        r_state <= RRead;
                    end
                end
                RRead: begin
                    if (rd_fire) begin
                        rd_addr <= rd_addr + ADDR_WIDTH'(1);
                        if (rel) begin
                            rd_buf  <= (rd_buf == LAST_BUF) ? '0 : rd_buf + BUF_W'(1);
                            r_state <= RIdle;
                        end
                    end
                end
                default: r_state <= RIdle;
            endcase
        end
    end

    // Committed-frame count; a same-cycle commit and release cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_count <= '0;
        end else begin
            case ({commit, rel})
                2'b10:   buf_count <= buf_count + CNT_W'(1);
                2'b01:   buf_count <= buf_count - CNT_W'(1);
                default: buf_count <= buf_count;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buf_multi.sv
// Directed bench for frame_buf_multi with default parameters (2 buffers of 8 words).
module tb_frame_buf_multi;

    logic        clk;
    logic        reset;
    logic        wr_en_in;
    logic        rd_en_in;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_valid;
    logic        wr_rdy;
    logic        frame_rdy;
    logic [1:0]  buf_count;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    frame_buf_multi #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(3),
        .NUM_BUFS  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en_in  (wr_en_in),
        .rd_en_in  (rd_en_in),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .wr_rdy    (wr_rdy),
        .frame_rdy (frame_rdy),
        .buf_count (buf_count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, {31'd0, data_valid}, 32'd0);
        chk({tag, "_dout"}, data_out, 32'd0);
        chk({tag, "_count"}, {30'd0, buf_count}, 32'd0);
        chk({tag, "_wr_rdy"}, {31'd0, wr_rdy}, 32'd1);
        chk({tag, "_frame_rdy"}, {31'd0, frame_rdy}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    endtask

    // Eight continuous writes base..base+7, enable released afterwards.
    task automatic write_frame(input logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            wr_en_in = 1'b0;
            data_in  = base + 32'(i);
            tick();
        end
        wr_en_in = 1'b1;
    endtask

    // Eight continuous reads, each word checked one cycle after issue.
    task automatic read_frame(input string tag, input logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            rd_en_in = 1'b0;
            tick();
            chk({tag, "_valid"}, {31'd0, data_valid}, 32'd1);
            chk({tag, "_data"}, data_out, base + 32'(i));
        end
        rd_en_in = 1'b1;
    endtask

    initial begin
        int k;
        reset    = 1'b1;
        wr_en_in = 1'b1;
        rd_en_in = 1'b1;
        data_in  = '0;

        // Reset applied with no clock edge yet.
        #2 reset = 1'b0;
        #1 chk_reset_state("rst0");
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Single frame write, commit visible the cycle after the last word.
        for (int i = 0; i < 8; i++) begin
            wr_en_in = 1'b0;
            data_in  = 32'(i);
            tick();
            if (i == 6) chk("single_rdy_early", {31'd0, frame_rdy}, 32'd0);
        end
        wr_en_in = 1'b1;
        chk("single_count", {30'd0, buf_count}, 32'd1);
        chk("single_frame_rdy", {31'd0, frame_rdy}, 32'd1);
        read_frame("single", 32'd0);
        chk("single_count_after", {30'd0, buf_count}, 32'd0);
        tick();
        chk("single_valid_off", {31'd0, data_valid}, 32'd0);
        chk("single_dout_hold", data_out, 32'd7);

        // Two frames fill the ring; the next word is dropped with an overflow pulse.
        write_frame(32'h10);
        write_frame(32'h20);
        chk("full_count", {30'd0, buf_count}, 32'd2);
        chk("full_wr_rdy", {31'd0, wr_rdy}, 32'd0);
        chk("full_ovf_idle", {31'd0, overflow}, 32'd0);
        wr_en_in = 1'b0;
        data_in  = 32'h30;
        tick();
        wr_en_in = 1'b1;
        chk("full_ovf_pulse", {31'd0, overflow}, 32'd1);
        chk("full_count_hold", {30'd0, buf_count}, 32'd2);
        tick();
        chk("full_ovf_clear", {31'd0, overflow}, 32'd0);
        read_frame("fullA", 32'h10);
        read_frame("fullB", 32'h20);
        chk("full_count_empty", {30'd0, buf_count}, 32'd0);
        tick();
        chk("full_valid_off", {31'd0, data_valid}, 32'd0);

        // Writes every other cycle.
        for (int c = 0; c < 16; c++) begin
            wr_en_in = (c % 2 == 0) ? 1'b0 : 1'b1;
            data_in  = 32'(c / 2);
            tick();
        end
        wr_en_in = 1'b1;
        chk("gap_count", {30'd0, buf_count}, 32'd1);
        // Reads 3 on / 2 off; data_valid follows the issue pattern.
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            rd_en_in = (c % 5 < 3) ? 1'b0 : 1'b1;
            tick();
            if (c % 5 < 3) begin
                chk("gap_valid_on", {31'd0, data_valid}, 32'd1);
                chk("gap_data", data_out, 32'(k));
                k++;
            end else begin
                chk("gap_valid_off", {31'd0, data_valid}, 32'd0);
                chk("gap_hold", data_out, 32'(k - 1));
            end
        end
        rd_en_in = 1'b1;
        chk("gap_words", 32'(k), 32'd8);
        chk("gap_count_empty", {30'd0, buf_count}, 32'd0);

        // Commit and release on the same edge.
        write_frame(32'h40);
        for (int i = 0; i < 8; i++) begin
            wr_en_in = 1'b0;
            rd_en_in = 1'b0;
            data_in  = 32'h50 + 32'(i);
            tick();
            chk("sim_data", data_out, 32'h40 + 32'(i));
        end
        wr_en_in = 1'b1;
        rd_en_in = 1'b1;
        chk("sim_count", {30'd0, buf_count}, 32'd1);
        chk("sim_frame_rdy", {31'd0, frame_rdy}, 32'd1);
        read_frame("sim_next", 32'h50);
        chk("sim_count_empty", {30'd0, buf_count}, 32'd0);

        // Reset mid-frame: buffer 1 half filled while buffer 0 is half read.
        reset = 1'b0;
        #2 reset = 1'b1;
        tick();
        write_frame(32'h60);
        for (int i = 0; i < 4; i++) begin
            wr_en_in = 1'b0;
            rd_en_in = 1'b0;
            data_in  = 32'h70 + 32'(i);
            tick();
        end
        chk("mid_valid_pre", {31'd0, data_valid}, 32'd1);
        chk("mid_data_pre", data_out, 32'h63);
        #2 reset = 1'b0;
        #1 chk_reset_state("rst_mid");
        wr_en_in = 1'b1;
        rd_en_in = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        write_frame(32'h80);
        chk("mid_count", {30'd0, buf_count}, 32'd1);
        chk("mid_wr_rdy", {31'd0, wr_rdy}, 32'd1);
        read_frame("mid_read", 32'h80);
        chk("mid_count_empty", {30'd0, buf_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
